// File: rtl/fft8_pkg.sv
// Shared constants for the 8-point FFT datapath: operand/output widths and the
// state encoding of the complex twiddle multiplier sequencer.
package fft8_pkg;

    localparam int IN_W   = 12;
    localparam int FRAC_W = 10;
    localparam int OUT_W  = 12;
    // One guard bit above a full product: two -2^(IN_W-1) squares can sum without wrapping.
    localparam int ACC_W  = 2 * IN_W + 1;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t MUL_RR = 3'd1;
    localparam state_t MUL_II = 3'd2;
    localparam state_t MUL_RI = 3'd3;
    localparam state_t MUL_IR = 3'd4;
    localparam state_t SCALE  = 3'd5;
    localparam state_t DONE   = 3'd6;

    function automatic state_t mul_next(input state_t s);
        case (s)
            MUL_RR:  return MUL_II;
            MUL_II:  return MUL_RI;
            MUL_RI:  return MUL_IR;
            default: return SCALE;
        endcase
    endfunction

endpackage

// File: rtl/cmul_seq_8_if.sv
// Bundle of the sequencer's input handshake, Booth multiplier bus and output handshake.
// slave = the sequencer's view, master = the environment driving it.
interface cmul_seq_8_if;
    import fft8_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [IN_W-1:0]   a_re;
    logic signed [IN_W-1:0]   a_im;
    logic signed [IN_W-1:0]   b_re;
    logic signed [IN_W-1:0]   b_im;
    logic                     mul_en;
    logic signed [IN_W-1:0]   mul_a;
    logic signed [IN_W-1:0]   mul_b;
    logic signed [2*IN_W-1:0] mul_p;
    logic                     mul_rdy;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  y_re;
    logic signed [OUT_W-1:0]  y_im;
    logic                     sat_flag;

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, mul_p, mul_rdy, out_ready,
        output in_ready, mul_en, mul_a, mul_b, out_valid, y_re, y_im, sat_flag
    );

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, mul_p, mul_rdy, out_ready,
        input  in_ready, mul_en, mul_a, mul_b, out_valid, y_re, y_im, sat_flag
    );

endinterface

// File: rtl/cmul_sat_8.sv
// Shift/saturate of one accumulator part down to OUT_W bits.
// CMUL_ROUND_EN selects round-half-up before the shift; otherwise plain truncation toward -inf.
module cmul_sat_8
    import fft8_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);

`ifdef CMUL_ROUND_EN
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) <<< (FRAC_W - 1);
    logic signed [SUM_W-1:0] sum;
    assign sum = $signed({acc[ACC_W-1], acc}) + HALF;
`else
    localparam int SUM_W = ACC_W;
    logic signed [SUM_W-1:0] sum;
    assign sum = acc;
`endif

    localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] Y_MIN = ~Y_MAX;

    logic signed [SUM_W-1:0] r;
    assign r = sum >>> FRAC_W;

    always_comb begin
        y   = r[OUT_W-1:0];
        sat = 1'b0;
        if (r > Y_MAX) begin
            y   = Y_MAX[OUT_W-1:0];
            sat = 1'b1;
        end else if (r < Y_MIN) begin
            y   = Y_MIN[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/cmul_seq_8.sv
// Complex twiddle multiplier sequencer: four passes through a shared Booth multiplier
// (rr, ii, ri, ir), then scale/saturate and hand off. Rounding via CMUL_ROUND_EN.
module cmul_seq_8
    import fft8_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    cmul_seq_8_if.slave  bus
);

    state_t                   state_q, state_d;
    logic                     issue_q, issue_d;
    logic signed [IN_W-1:0]   ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic signed [ACC_W-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [OUT_W-1:0]  y_re_q, y_re_d, y_im_q, y_im_d;
    logic                     sat_q, sat_d;

    logic signed [ACC_W-1:0]  p_ext;
    logic signed [OUT_W-1:0]  sat_y_re, sat_y_im;
    logic                     sat_re, sat_im;

    assign p_ext = {bus.mul_p[2*IN_W-1], bus.mul_p};

    cmul_sat_8 u_sat_re (.acc(acc_re_q), .y(sat_y_re), .sat(sat_re));
    cmul_sat_8 u_sat_im (.acc(acc_im_q), .y(sat_y_im), .sat(sat_im));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            issue_q  <= 1'b0;
            ar_q     <= '0;
            ai_q     <= '0;
            br_q     <= '0;
            bi_q     <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            y_re_q   <= '0;
            y_im_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            issue_q  <= issue_d;
            ar_q     <= ar_d;
            ai_q     <= ai_d;
            br_q     <= br_d;
            bi_q     <= bi_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            y_re_q   <= y_re_d;
            y_im_q   <= y_im_d;
            sat_q    <= sat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        issue_d  = issue_q;
        ar_d     = ar_q;
        ai_d     = ai_q;
        br_d     = br_q;
        bi_d     = bi_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        y_re_d   = y_re_q;
        y_im_d   = y_im_q;
        sat_d    = sat_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    ar_d     = bus.a_re;
                    ai_d     = bus.a_im;
                    br_d     = bus.b_re;
                    bi_d     = bus.b_im;
                    acc_re_d = '0;
                    acc_im_d = '0;
                    state_d  = MUL_RR;
                    issue_d  = 1'b1;
                end
            end
            MUL_RR, MUL_II, MUL_RI, MUL_IR: begin
                // A ready strobe seen in the issue cycle belongs to the previous product.
                if (issue_q) begin
                    issue_d = 1'b0;
                end else if (bus.mul_rdy) begin
                    case (state_q)
                        MUL_RR:  acc_re_d = acc_re_q + p_ext;
                        MUL_II:  acc_re_d = acc_re_q - p_ext;
                        default: acc_im_d = acc_im_q + p_ext;
                    endcase
                    state_d = mul_next(state_q);
                    issue_d = (state_q != MUL_IR);
                end
            end
            SCALE: begin
                y_re_d  = sat_y_re;
                y_im_d  = sat_y_im;
                sat_d   = sat_re | sat_im;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.mul_en    = 1'b0;
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        bus.y_re      = y_re_q;
        bus.y_im      = y_im_q;
        bus.sat_flag  = sat_q;
        case (state_q)
            MUL_RR: begin bus.mul_en = issue_q; bus.mul_a = ar_q; bus.mul_b = br_q; end
            MUL_II: begin bus.mul_en = issue_q; bus.mul_a = ai_q; bus.mul_b = bi_q; end
            MUL_RI: begin bus.mul_en = issue_q; bus.mul_a = ar_q; bus.mul_b = bi_q; end
            MUL_IR: begin bus.mul_en = issue_q; bus.mul_a = ai_q; bus.mul_b = br_q; end
            default: ;
        endcase
    end

endmodule
